// File: rtl/div_pkg.sv
// div_pkg: default divider geometry, the buffered result entry layout and
// the occupancy-counter sizing helper shared by div_result_buf and div_fifo.
package div_pkg;

  localparam int DIV_N     = 5;
  localparam int DIV_M     = 3;
  localparam int DIV_LAT   = 5;
  localparam int DIV_DEPTH = 4;

  typedef struct packed {
    logic [DIV_N-1:0] dividend;
    logic [DIV_M-1:0] divisor;
    logic [DIV_N-1:0] merchant;
    logic [DIV_M-1:0] remainder;
    logic             dz;
    logic             chk_err;
  } div_entry_t;

  // Wide enough for every op that can be in the delay line plus the FIFO.
  function automatic int div_occupancy_w(input int lat, input int depth);
    return $clog2(lat + depth + 1);
  endfunction

endpackage

// File: rtl/div_fifo.sv
// div_fifo: first-word-fall-through FIFO of div_entry_t; pointers wrap modulo
// DEPTH so any depth >= 1 works. A write when full is only taken with a pop.
module div_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = DIV_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  div_entry_t    wr_data_i,
  input  logic          rd_en_i,
  output div_entry_t    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  div_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr_s, do_rd_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rptr_q];

  always_comb begin
    do_wr_s = wr_en_i && (!full_o || rd_en_i);
    do_rd_s = rd_en_i && !empty_o;
    wptr_d  = do_wr_s ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_rd_s ? ptr_inc(rptr_q) : rptr_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {$bits(div_entry_t){1'b0}};
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_wr_s) begin
        mem_q[wptr_q] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/div_result_buf.sv
// div_result_buf: realigns operands with divider results, buffers them and grants issue credit.
// Defining DIV_RESULT_CHECK_EN adds a merchant*divisor+remainder self-check per entry.
module div_result_buf
  import div_pkg::*;
#(
  parameter int N     = DIV_N,     // must match div_entry_t field widths
  parameter int M     = DIV_M,
  parameter int LAT   = DIV_LAT,
  parameter int DEPTH = DIV_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_dividend,
  input  logic [M-1:0] in_divisor,
  output logic         issue_ok,
  input  logic         div_res_rdy,
  input  logic [N-1:0] div_merchant,
  input  logic [M-1:0] div_remainder,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_dividend,
  output logic [M-1:0] out_divisor,
  output logic [N-1:0] out_merchant,
  output logic [M-1:0] out_remainder,
  output logic         out_dz,
  output logic         out_chk_err,
  output logic         err_ovf,
  output logic         err_align
);

  localparam int OW = div_occupancy_w(LAT, DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LAT-1:0] dl_v_q;
  logic [N-1:0]   dl_a_q [LAT];
  logic [M-1:0]   dl_b_q [LAT];
  logic [OW-1:0]  inflight_q, inflight_d;
  logic           err_ovf_q, err_ovf_d, err_align_q, err_align_d;
  logic           head_v_s, pop_s, full_s, empty_s, chk_err_s;
  logic [N-1:0]   head_a_s, res_q_s;
  logic [M-1:0]   head_b_s, res_r_s;
  logic [CW-1:0]  count_s;
  div_entry_t     wr_entry_s, rd_entry_s;

  // Operand delay line: an op issued in cycle t reaches the head in t+LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v_q <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        dl_a_q[i] <= {N{1'b0}};
        dl_b_q[i] <= {M{1'b0}};
      end
    end else begin
      dl_v_q[0] <= in_valid;
      dl_a_q[0] <= in_dividend;
      dl_b_q[0] <= in_divisor;
      for (int i = 1; i < LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_a_q[i] <= dl_a_q[i-1];
        dl_b_q[i] <= dl_b_q[i-1];
      end
    end
  end

  assign head_v_s  = dl_v_q[LAT-1];
  assign head_a_s  = dl_a_q[LAT-1];
  assign head_b_s  = dl_b_q[LAT-1];
  assign res_q_s   = div_res_rdy ? div_merchant : {N{1'b0}};
  assign res_r_s   = div_res_rdy ? div_remainder : {M{1'b0}};
  assign out_valid = !empty_s;
  assign pop_s     = out_valid && out_ready;
  assign issue_ok  = (inflight_q + OW'(count_s)) < OW'(DEPTH);

`ifdef DIV_RESULT_CHECK_EN
  logic [N+M-1:0] recon_s;
  always_comb begin
    recon_s   = (N+M)'(res_q_s) * (N+M)'(head_b_s) + (N+M)'(res_r_s);
    chk_err_s = (recon_s != (N+M)'(head_a_s)) && (head_b_s != {M{1'b0}});
  end
  assign out_chk_err = rd_entry_s.chk_err;
`else
  logic unused_chk_s;
  assign chk_err_s    = 1'b0;
  assign unused_chk_s = rd_entry_s.chk_err;
  assign out_chk_err  = 1'b0;
`endif

  assign wr_entry_s = {head_a_s, head_b_s, res_q_s, res_r_s,
                       (head_b_s == {M{1'b0}}), chk_err_s};

  always_comb begin
    inflight_d  = inflight_q;
    err_ovf_d   = err_ovf_q;
    err_align_d = err_align_q;
    if (in_valid && !head_v_s) begin
      inflight_d = inflight_q + OW'(1);
    end else if (!in_valid && head_v_s) begin
      inflight_d = inflight_q - OW'(1);
    end else begin
      inflight_d = inflight_q;
    end
    if ((head_v_s && full_s && !pop_s) || (in_valid && !issue_ok)) begin
      err_ovf_d = 1'b1;
    end else begin
      err_ovf_d = err_ovf_q;
    end
    if (head_v_s ^ div_res_rdy) begin
      err_align_d = 1'b1;
    end else begin
      err_align_d = err_align_q;
    end
  end

  // Credit counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= {OW{1'b0}};
      err_ovf_q   <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      err_ovf_q   <= err_ovf_d;
      err_align_q <= err_align_d;
    end
  end

  assign err_ovf   = err_ovf_q;
  assign err_align = err_align_q;

  div_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (head_v_s),
    .wr_data_i (wr_entry_s),
    .rd_en_i   (pop_s),
    .rd_data_o (rd_entry_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (count_s)
  );

  assign out_dividend  = rd_entry_s.dividend;
  assign out_divisor   = rd_entry_s.divisor;
  assign out_merchant  = rd_entry_s.merchant;
  assign out_remainder = rd_entry_s.remainder;
  assign out_dz        = rd_entry_s.dz;

endmodule

// File: doc/div_result_buf.md
Name: div_result_buf

Overview:
- Sits directly downstream of the pipelined divider `divider_man`.
- Taps the operands issued to the divider and delays them LAT cycles so they line up with each res_rdy beat.
- Stores {operands, merchant, remainder, divide-by-zero flag} in a DEPTH-entry FIFO and presents entries to the consumer over valid/ready.
- The divider cannot stall, so this block issues credit (issue_ok) upstream so that every in-flight result is guaranteed a slot.

Parameters:
- N, 5, dividend/merchant width.
- M, 3, divisor/remainder width.
- LAT, 5, divider latency in cycles from data_rdy to res_rdy (equals divider N).
- DEPTH, 4, result FIFO entries (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset; also drives the divider's reset (inverted), so both clear together.
- in_valid  in  1  operand pair issued to the divider this cycle (same strobe as divider data_rdy).
- in_dividend  in  N  dividend issued.
- in_divisor  in  M  divisor issued.
- issue_ok  out  1  upstream may assert in_valid this cycle.
- div_res_rdy  in  1  divider result valid.
- div_merchant  in  N  divider quotient.
- div_remainder  in  M  divider remainder.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_dividend  out  N  head operand.
- out_divisor  out  M  head operand.
- out_merchant  out  N  head quotient.
- out_remainder  out  M  head remainder.
- out_dz  out  1  head divisor was zero.
- out_chk_err  out  1  head failed self-check (see Optional Feature).
- err_ovf  out  1  sticky: write while full, or in_valid while !issue_ok.
- err_align  out  1  sticky: div_res_rdy disagrees with delay-line valid.

Behaviour:
- Reset: all counters, pointers and delay-line valids cleared; out_valid=0, issue_ok=1, err_ovf=0, err_align=0. Data outputs are don't-care (may be zeroed).
- Delay line: LAT-stage shift register of {v, dividend, divisor}; stage0 <= {in_valid, in_dividend, in_divisor} every cycle; head is stage LAT-1.
- The head is valid in the same cycle that div_res_rdy for that op is high: op issued in cycle t appears in cycle t+LAT.
- In-flight counter, width clog2(LAT+DEPTH+1): +1 on in_valid, -1 on head valid; both in the same cycle means no change.
- issue_ok = (inflight + fifo_count) < DEPTH, combinational.
- Write: when head valid, write entry {head dividend, head divisor, div_merchant, div_remainder, dz = (head divisor==0)}.
- Divide-by-zero: merchant and remainder are stored unchanged from the divider.
- Alignment: head valid XOR div_res_rdy sets err_align. A result without a head is not written; a head without a result is written with merchant/remainder = 0.
- FIFO is first-word-fall-through: out_valid = (count != 0); out_* driven from the read pointer.
- Pop on out_valid && out_ready. Pointers wrap modulo DEPTH (DEPTH need not be a power of two).
- Full, write and pop in the same cycle: both performed, count unchanged.
- Write while full without pop: entry dropped, err_ovf set.
- Empty: pop ignored.
- Latency: in_valid cycle t → out_valid at cycle t+LAT+1 if the FIFO was empty.
- Sustained throughput: 1 result/cycle when out_ready is held high.
- Sticky errors clear only on rst.
- Reset mid-operation: everything cleared immediately (async). In-flight ops are discarded; the divider's reset clears its pipeline too.

Optional Feature:
- Macro: DIV_RESULT_CHECK_EN.
- Defined: on write, compute merchant*divisor + remainder at N+M bits and compare to the dividend. Set the stored chk_err bit if they differ and the divisor is nonzero; it is presented on out_chk_err.
- Not defined: no multiplier, no stored bit, out_chk_err tied 0.

Decomposition:
- Package div_pkg:
  - Default N/M/LAT/DEPTH localparams.
  - Typedef div_entry_t: packed struct {dividend, divisor, merchant, remainder, dz, chk_err}, parameterised via N/M defaults.
  - Function div_occupancy_w(LAT, DEPTH) returning counter width.
- Sub-module div_fifo: generic FWFT FIFO of div_entry_t with wr/rd/full/empty/count. The delay line, credit counter and checker stay in the top.

Test Plan:
- Reset: assert rst mid-stream with 3 ops in flight → next cycle out_valid=0, issue_ok=1, errors 0; no stale output after deassert.
- Single op: 25/5 at cycle 0, divider returns 5 r0 at cycle 5 → out_valid at cycle 6 with 25,5,5,0, out_dz=0.
- Backpressure: out_ready=0, issue 4 back-to-back ops (16/3, 10/4, 15/1, 31/7) → issue_ok=0 from the cycle after the 4th issue. FIFO fills to 4 in order. Raise out_ready → heads 5r1, 2r2, 15r0, 4r3 on consecutive cycles; issue_ok returns after the first pop.
- Divide by zero: 16/0, divider returns 31 r0 → out_dz=1, merchant 31 passed through.
- Alignment: pulse div_res_rdy at cycle 3 with no op issued → err_align=1 and stays 1 through later good ops until rst.
- Feature on: op 16/3 with divider forced to return 4 r0 → out_chk_err=1. A correct 5 r1 gives 0. Feature off: out_chk_err=0 always.
